// File: rtl/mem_access_ctrl.sv
// Initiator side of the CPU memory interface: latches one read or write request
// (MAR + write buffer), strobes the synchronous RAM once and captures read data into the MDR.
module mem_access_ctrl #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (READ_LAT < 1) begin : g_lat_check
    $error("mem_access_ctrl: READ_LAT must be >= 1");
  end

  localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t             state_reg;
  logic [ADDR_W-1:0]  mar_reg;
  logic [DATA_W-1:0]  wbuf_reg;
  logic [DATA_W-1:0]  rdata_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               mem_read_reg;
  logic               mem_write_reg;

  // Output registers are loaded with the value belonging to the state being
  // entered, so each one always matches a decode of state_reg.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      mar_reg       <= '0;
      wbuf_reg      <= '0;
      rdata_reg     <= '0;
      cnt_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
    end else begin
      done_reg      <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            mar_reg  <= addr;
            wbuf_reg <= wdata;
            busy_reg <= 1'b1;
            if (wr) begin
              state_reg     <= WR;
              mem_write_reg <= 1'b1;
            end else begin
              state_reg    <= RD;
              mem_read_reg <= 1'b1;
            end
          end
        end
        WR: begin
          state_reg <= DONE;
          done_reg  <= 1'b1;
        end
        RD: begin
          cnt_reg   <= CNT_INIT;
          state_reg <= RWAIT;
        end
        RWAIT: begin
          // RAM data is valid during the last RWAIT cycle; capture it at its end.
          if (cnt_reg == '0) begin
            rdata_reg <= mem_rdata;
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign rdata     = rdata_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;
  assign mem_read  = mem_read_reg;
  assign mem_write = mem_write_reg;
  assign mem_addr  = mar_reg;
  assign mem_wdata = wbuf_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: one instance with READ_LAT=1 and one with READ_LAT=3,
// each attached to its own behavioural synchronous RAM.
module tb_mem_access_ctrl;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        req1, req3, wr;
  logic [8:0]  addr;
  logic [31:0] wdata;

  logic [31:0] rdata1, mwd1, mrdata1, rdata3, mwd3, mrdata3;
  logic [8:0]  maddr1, maddr3;
  logic        busy1, done1, mrd1, mwr1, busy3, done3, mrd3, mwr3;

  always #5 Clock = ~Clock;

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(9), .READ_LAT(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .req(req1), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .busy(busy1), .done(done1), .mem_read(mrd1), .mem_write(mwr1),
    .mem_addr(maddr1), .mem_wdata(mwd1), .mem_rdata(mrdata1)
  );

  mem_access_ctrl #(.DATA_W(32), .ADDR_W(9), .READ_LAT(3)) dut3 (
    .Clock(Clock), .Resetn(Resetn), .req(req3), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .busy(busy3), .done(done3), .mem_read(mrd3), .mem_write(mwr3),
    .mem_addr(maddr3), .mem_wdata(mwd3), .mem_rdata(mrdata3)
  );

  // RAM models: data appears READ_LAT cycles after the edge that samples mem_read.
  logic [31:0] ram1 [512];
  logic [31:0] ram3 [512];
  logic [31:0] p1;
  logic [31:0] p3 [3];

  always @(posedge Clock) begin
    if (mwr1) ram1[maddr1] <= mwd1;
    if (mrd1) p1 <= ram1[maddr1];
  end
  always @(posedge Clock) begin
    if (mwr3) ram3[maddr3] <= mwd3;
    if (mrd3) p3[0] <= ram3[maddr3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign mrdata1 = p1;
  assign mrdata3 = p3[2];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mrd;
    logic        mwr;
    logic [8:0]  maddr;
    logic [31:0] mwd;
    logic [31:0] rdata;
  } obs_t;

  function automatic obs_t get_obs(input bit s);
    obs_t o;
    if (s) o = '{busy3, done3, mrd3, mwr3, maddr3, mwd3, rdata3};
    else   o = '{busy1, done1, mrd1, mwr1, maddr1, mwd1, rdata1};
    return o;
  endfunction

  typedef struct {
    bit          sel;
    bit          w;
    logic [31:0] exp;
  } sb_t;
  sb_t         sbq[$];
  logic [31:0] last_rd [2];

  typedef struct {
    bit          sel;
    bit          w;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs [12];

  // One complete access, driven in cycle 0 (task entered #1 after a posedge, DUT idle).
  task automatic do_access(input bit s, input bit w, input logic [8:0] a,
                           input logic [31:0] d, input logic [31:0] exp_rd);
    int   lat;
    int   exp_cyc;
    int   cyc;
    obs_t o;
    sb_t  e;
    lat     = s ? 3 : 1;
    exp_cyc = w ? 2 : 2 + lat;
    wr = w; addr = a; wdata = d;
    if (s) req3 = 1'b1; else req1 = 1'b1;
    sbq.push_back('{s, w, (w ? last_rd[s] : exp_rd)});
    @(posedge Clock); #1;
    req1 = 1'b0; req3 = 1'b0;
    o = get_obs(s);
    check("cycle1_mem_read", 32'(o.mrd), 32'(!w));
    check("cycle1_mem_write", 32'(o.mwr), 32'(w));
    check("cycle1_mem_addr", 32'(o.maddr), 32'(a));
    if (w) check("cycle1_mem_wdata", o.mwd, d);
    check("cycle1_busy", 32'(o.busy), 32'd1);
    cyc = 1;
    while (cyc < exp_cyc + 4) begin
      @(posedge Clock); #1;
      cyc++;
      o = get_obs(s);
      if (o.done) break;
    end
    check("done_cycle", 32'(cyc), 32'(exp_cyc));
    e = sbq.pop_front();
    if (o.done) begin
      check(e.w ? "rdata_after_write" : "rdata_after_read", o.rdata, e.exp);
      check("busy_in_done", 32'(o.busy), 32'd1);
    end
    if (!w) last_rd[s] = exp_rd;
    @(posedge Clock); #1;
    o = get_obs(s);
    check("idle_done_low", 32'(o.done), 32'd0);
    check("idle_busy_low", 32'(o.busy), 32'd0);
    $display("[TB] %s lat%0d addr=%h wdata=%h rdata=%h done_cycle=%0d",
             w ? "WRITE" : "READ ", lat, a, d, o.rdata, cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   nrd, nwr, ndone;
    Resetn = 1'b0; req1 = 1'b0; req3 = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    last_rd[0] = '0; last_rd[1] = '0;

    vecs[0]  = '{0, 1, 9'h1F0, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{0, 0, 9'h1F0, 32'h0,        32'hDEADBEEF};
    vecs[2]  = '{0, 1, 9'h005, 32'hCAFEF00D, 32'h0};
    vecs[3]  = '{0, 1, 9'h1F0, 32'h11111111, 32'h0};
    vecs[4]  = '{0, 0, 9'h005, 32'h0,        32'hCAFEF00D};
    vecs[5]  = '{0, 0, 9'h1F0, 32'h0,        32'h11111111};
    vecs[6]  = '{0, 1, 9'h1FF, 32'hA5A5A5A5, 32'h0};
    vecs[7]  = '{0, 0, 9'h1FF, 32'h0,        32'hA5A5A5A5};
    vecs[8]  = '{1, 1, 9'h000, 32'h12345678, 32'h0};
    vecs[9]  = '{1, 1, 9'h001, 32'h87654321, 32'h0};
    vecs[10] = '{1, 0, 9'h000, 32'h0,        32'h12345678};
    vecs[11] = '{1, 0, 9'h001, 32'h0,        32'h87654321};

    // Reset state
    #12;
    for (int s = 0; s < 2; s++) begin
      o = get_obs(s[0]);
      check("reset_busy", 32'(o.busy), 32'd0);
      check("reset_done", 32'(o.done), 32'd0);
      check("reset_strobes", 32'({o.mrd, o.mwr}), 32'd0);
      check("reset_mem_addr", 32'(o.maddr), 32'd0);
      check("reset_mem_wdata", o.mwd, 32'd0);
      check("reset_rdata", o.rdata, 32'd0);
    end
    Resetn = 1'b1;
    @(posedge Clock); #1;

    for (int i = 0; i < 12; i++)
      do_access(vecs[i].sel, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd);

    // req pulsed during a read is dropped: one read strobe, one done, no write
    nrd = 0; nwr = 0; ndone = 0;
    req1 = 1'b1; wr = 1'b0; addr = 9'h005; wdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge Clock); #1;
      o = get_obs(0);
      nrd += int'(o.mrd); nwr += int'(o.mwr); ndone += int'(o.done);
      if (i == 1) begin req1 = 1'b1; wr = 1'b1; addr = 9'h010; wdata = 32'h55AA55AA; end
      else req1 = 1'b0;
    end
    check("busy_drop_read_strobes", 32'(nrd), 32'd1);
    check("busy_drop_write_strobes", 32'(nwr), 32'd0);
    check("busy_drop_dones", 32'(ndone), 32'd1);
    check("busy_drop_rdata", rdata1, 32'hCAFEF00D);
    $display("[TB] BUSYDROP reads=%0d writes=%0d dones=%0d rdata=%h", nrd, nwr, ndone, rdata1);

    // req held high: write 0 to 0x1FF, then read it back (rdata was 0xCAFEF00D)
    req1 = 1'b1; wr = 1'b1; addr = 9'h1FF; wdata = 32'h0;
    @(posedge Clock); #1;
    check("b2b_c1_mem_write", 32'(mwr1), 32'd1);
    @(posedge Clock); #1;
    check("b2b_c2_done", 32'(done1), 32'd1);
    wr = 1'b0;
    @(posedge Clock); #1;
    check("b2b_c3_idle", 32'(busy1), 32'd0);
    @(posedge Clock); #1;
    check("b2b_c4_mem_read", 32'(mrd1), 32'd1);
    check("b2b_c4_mem_addr", 32'(maddr1), 32'h1FF);
    @(posedge Clock); #1;
    check("b2b_c5_wait", 32'({busy1, done1}), 32'b10);
    @(posedge Clock); #1;
    req1 = 1'b0;
    check("b2b_c6_done", 32'(done1), 32'd1);
    check("b2b_c6_rdata", rdata1, 32'h0);
    @(posedge Clock); #1;
    check("b2b_c7_idle", 32'(busy1), 32'd0);
    last_rd[0] = 32'h0;
    $display("[TB] BACK2BACK 0x1FF rdata=%h", rdata1);

    // Reset asserted during RWAIT aborts the read; first make rdata nonzero
    do_access(0, 0, 9'h005, 32'h0, 32'hCAFEF00D);
    req1 = 1'b1; wr = 1'b0; addr = 9'h1F0;
    @(posedge Clock); #1;
    req1 = 1'b0;
    @(posedge Clock); #1;
    check("pre_reset_busy", 32'(busy1), 32'd1);
    #2 Resetn = 1'b0;
    #1;
    check("midreset_mem_read", 32'(mrd1), 32'd0);
    check("midreset_busy", 32'(busy1), 32'd0);
    check("midreset_done", 32'(done1), 32'd0);
    check("midreset_rdata", rdata1, 32'h0);
    #3 Resetn = 1'b1;
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      ndone += int'(done1) + int'(busy1);
    end
    check("post_reset_no_done", 32'(ndone), 32'd0);
    $display("[TB] RESET mid-read rdata=%h busy=%b", rdata1, busy1);
    last_rd[0] = 32'h0; last_rd[1] = 32'h0;
    do_access(0, 0, 9'h1F0, 32'h0, 32'h11111111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
